// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - captures two 4-input truth tables and compares them (optional mism_map via MISMATCH_MAP_EN)
module truth_table_checker #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  idx,
    input  logic        s1,
    input  logic        s2,
    output logic        done,
    output logic        equal,
    output logic [4:0]  mism_cnt,
    output logic [3:0]  first_mism,
    output logic [15:0] tt1,
    output logic [15:0] tt2,
    output logic        timeout
`ifdef MISMATCH_MAP_EN
    ,
    output logic [15:0] mism_map
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE, ABORT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   tt1_q, tt1_d, tt2_q, tt2_d, cov_q, cov_d;
    logic [CW-1:0] idle_q, idle_d;
    logic          done_q, done_d, equal_q, equal_d, timeout_q, timeout_d;
    logic [4:0]    mism_cnt_q, mism_cnt_d;
    logic [3:0]    first_mism_q, first_mism_d;
`ifdef MISMATCH_MAP_EN
    logic [15:0]   map_q, map_d;
`endif

    // Tables as they would look if this cycle's sample is accepted
    logic [15:0] nt1, nt2, ncov, diff;
    logic [4:0]  cnt;
    logic [3:0]  low;
    logic        accept;

    always_comb begin
        accept = (state_q == CAPTURE) && in_valid;
        nt1 = tt1_q;
        nt2 = tt2_q;
        ncov = cov_q;
        nt1[idx] = s1;
        nt2[idx] = s2;
        ncov[idx] = 1'b1;
        diff = nt1 ^ nt2;
        cnt = '0;
        low = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, diff[i]};
        end
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) low = 4'(i);
        end

        state_d      = state_q;
        tt1_d        = tt1_q;
        tt2_d        = tt2_q;
        cov_d        = cov_q;
        idle_d       = idle_q;
        done_d       = done_q;
        equal_d      = equal_q;
        timeout_d    = timeout_q;
        mism_cnt_d   = mism_cnt_q;
        first_mism_d = first_mism_q;
`ifdef MISMATCH_MAP_EN
        map_d        = map_q;
`endif

        case (state_q)
            CAPTURE: begin
                if (accept) begin
                    tt1_d  = nt1;
                    tt2_d  = nt2;
                    cov_d  = ncov;
                    idle_d = '0;
                    if (&ncov) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        mism_cnt_d   = cnt;
                        equal_d      = (cnt == 5'd0);
                        first_mism_d = low;
`ifdef MISMATCH_MAP_EN
                        map_d        = diff;
`endif
                    end
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_d == CW'(TIMEOUT_CYCLES)) begin
                        state_d   = ABORT;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d      = CAPTURE;
                    tt1_d        = '0;
                    tt2_d        = '0;
                    cov_d        = '0;
                    idle_d       = '0;
                    done_d       = 1'b0;
                    equal_d      = 1'b0;
                    timeout_d    = 1'b0;
                    mism_cnt_d   = '0;
                    first_mism_d = '0;
`ifdef MISMATCH_MAP_EN
                    map_d        = '0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tt1_q        <= '0;
            tt2_q        <= '0;
            cov_q        <= '0;
            idle_q       <= '0;
            done_q       <= 1'b0;
            equal_q      <= 1'b0;
            timeout_q    <= 1'b0;
            mism_cnt_q   <= '0;
            first_mism_q <= '0;
`ifdef MISMATCH_MAP_EN
            map_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tt1_q        <= tt1_d;
            tt2_q        <= tt2_d;
            cov_q        <= cov_d;
            idle_q       <= idle_d;
            done_q       <= done_d;
            equal_q      <= equal_d;
            timeout_q    <= timeout_d;
            mism_cnt_q   <= mism_cnt_d;
            first_mism_q <= first_mism_d;
`ifdef MISMATCH_MAP_EN
            map_q        <= map_d;
`endif
        end
    end

    assign in_ready   = (state_q == CAPTURE);
    assign done       = done_q;
    assign equal      = equal_q;
    assign mism_cnt   = mism_cnt_q;
    assign first_mism = first_mism_q;
    assign tt1        = tt1_q;
    assign tt2        = tt2_q;
    assign timeout    = timeout_q;
`ifdef MISMATCH_MAP_EN
    assign mism_map   = map_q;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - randomized and directed bench for truth_table_checker against a behavioural model
module tb_truth_table_checker;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  idx = '0;
    logic        s1 = 1'b0;
    logic        s2 = 1'b0;
    logic        done, equal, timeout;
    logic [4:0]  mism_cnt;
    logic [3:0]  first_mism;
    logic [15:0] tt1, tt2;
`ifdef MISMATCH_MAP_EN
    logic [15:0] mism_map;
`endif

    truth_table_checker #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .idx(idx), .s1(s1), .s2(s2), .done(done),
        .equal(equal), .mism_cnt(mism_cnt), .first_mism(first_mism),
        .tt1(tt1), .tt2(tt2), .timeout(timeout)
`ifdef MISMATCH_MAP_EN
        , .mism_map(mism_map)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: run/finished/aborted flags plus per-minterm arrays
    bit m_run, m_fin, m_abt;
    bit m1[16];
    bit m2[16];
    bit mseen[16];
    int m_idle, r_cnt, r_first;

    function automatic logic [15:0] pack(input bit a[16]);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m1[i] = 0; m2[i] = 0; mseen[i] = 0;
        end
        m_idle = 0; r_cnt = 0; r_first = 0;
    endtask

    task automatic model_step();
        int n;
        if (reset) begin
            model_clear();
            m_run = 0; m_fin = 0; m_abt = 0;
        end else if (m_run) begin
            if (in_valid) begin
                m1[idx] = s1; m2[idx] = s2; mseen[idx] = 1; m_idle = 0;
                n = 0;
                for (int i = 0; i < 16; i++) if (mseen[i]) n++;
                if (n == 16) begin
                    m_run = 0; m_fin = 1;
                    r_cnt = 0; r_first = -1;
                    for (int i = 0; i < 16; i++) begin
                        if (m1[i] != m2[i]) begin
                            r_cnt++;
                            if (r_first < 0) r_first = i;
                        end
                    end
                    if (r_first < 0) r_first = 0;
                end
            end else begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_run = 0; m_abt = 1;
                end
            end
        end else if (start) begin
            model_clear();
            m_run = 1; m_fin = 0; m_abt = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare();
        chk("in_ready", in_ready, m_run);
        chk("done", done, m_fin);
        chk("timeout", timeout, m_abt);
        chk("equal", equal, m_fin && r_cnt == 0);
        chk("mism_cnt", mism_cnt, m_fin ? r_cnt : 0);
        chk("first_mism", first_mism, m_fin ? r_first : 0);
        chk("tt1", tt1, pack(m1));
        chk("tt2", tt2, pack(m2));
`ifdef MISMATCH_MAP_EN
        chk("mism_map", mism_map, m_fin ? (pack(m1) ^ pack(m2)) : 16'h0);
`endif
    endtask

    // Model advances on the inputs the DUT will sample; outputs compared 1ns after the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic send(input int i, input bit a, input bit b);
        in_valid = 1; idx = 4'(i); s1 = a; s2 = b;
        tick();
        in_valid = 0;
    endtask

    task automatic run_basic();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("basic_not_done_early", done, 0);
            send(i, (i >= 8 && i <= 14), (i != 7));
        end
        chk("basic_done", done, 1);
        chk("basic_tt1", tt1, 16'h7F00);
        chk("basic_tt2", tt2, 16'hFF7F);
        chk("basic_cnt", mism_cnt, 8);
        chk("basic_first", first_mism, 0);
        chk("basic_equal", equal, 0);
        chk("model_tt1", pack(m1), 16'h7F00);
        chk("model_cnt", r_cnt, 8);
`ifdef MISMATCH_MAP_EN
        chk("basic_map", mism_map, 16'h807F);
`endif
    endtask

    initial begin
        model_clear();
        m_run = 0; m_fin = 0; m_abt = 0;
        tick(); tick();
        reset = 0;
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_tt1", tt1, 16'h0);

        run_basic();

        // reverse order, s1 = s2 = idx[0]
        start = 1; tick(); start = 0;
        for (int i = 15; i >= 0; i--) send(i, i[0], i[0]);
        chk("rev_done", done, 1);
        chk("rev_equal", equal, 1);
        chk("rev_cnt", mism_cnt, 0);
        chk("rev_tt1", tt1, 16'hAAAA);
        chk("rev_tt2", tt2, 16'hAAAA);

        // in_valid held in DONE, then start with in_valid still high
        in_valid = 1; idx = 4'd5; s1 = 1; s2 = 0;
        tick(); tick(); tick();
        chk("hold_tt1", tt1, 16'hAAAA);
        start = 1; tick(); start = 0;
        chk("start_no_accept", tt1, 16'h0);
        chk("start_ready", in_ready, 1);
        tick();
        chk("first_accept", tt1, 16'h0020);
        in_valid = 0;

        // repeated index 3
        start = 1; tick(); start = 0;
        send(3, 1, 1);
        for (int i = 0; i < 3; i++) send(i, i[1], i[1]);
        send(3, 0, 0);
        for (int i = 4; i < 16; i++) begin
            if (i == 15) chk("rep_not_done", done, 0);
            send(i, i[1], i[1]);
        end
        chk("rep_tt1_3", tt1[3], 0);
        chk("rep_done", done, 1);
        chk("rep_equal", equal, 1);

        // timeout
        start = 1; tick(); start = 0;
        for (int i = 0; i < 5; i++) send(i, 1, 0);
        for (int c = 0; c < TO - 1; c++) tick();
        chk("to_early", timeout, 0);
        tick();
        chk("to_set", timeout, 1);
        chk("to_done", done, 0);
        chk("to_ready", in_ready, 0);
        chk("to_tt1", tt1, 16'h001F);

        // reset mid-capture, reset beats start/in_valid, then a clean run
        start = 1; tick(); start = 0;
        for (int i = 0; i < 10; i++) send(i, 1, 1);
        reset = 1; start = 1; in_valid = 1; tick();
        reset = 0; start = 0; in_valid = 0;
        chk("rst_mid_ready", in_ready, 0);
        chk("rst_mid_tt1", tt1, 16'h0);
        run_basic();

        // randomized traffic
        for (int run = 0; run < 40; run++) begin
            start = 1; tick(); start = 0;
            if ($urandom_range(0, 9) == 0) begin
                for (int c = 0; c < TO + 6; c++) tick();
            end
            for (int c = 0; c < 100; c++) begin
                int r;
                r = $urandom_range(0, 99);
                reset = (r < 1);
                start = (r >= 1 && r < 4);
                in_valid = ($urandom_range(0, 9) < 7);
                idx = 4'($urandom);
                s1 = 1'($urandom);
                s2 = ($urandom_range(0, 3) == 0) ? ~s1 : s1;
                tick();
            end
            reset = 0; start = 0; in_valid = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
